// File: rtl/sc_io_bus.sv
// sc_io_bus: memory-mapped I/O block for the single-cycle computer.
// It provides output-port registers, synchronised input ports with sticky
// change flags, and a down-counting timer. A masked interrupt is derived
// from the status flags. Reads are combinational; all state updates on the
// rising clock edge.
module sc_io_bus #(
   parameter int DATA_W = 32,
   parameter int N_OUT  = 3,
   parameter int N_IN   = 2,
   parameter int ADDR_W = 8
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     we,
   input  logic [N_IN*DATA_W-1:0]   in_port,
   output logic [N_OUT*DATA_W-1:0]  out_port,
   output logic                     io_sel,
   output logic [DATA_W-1:0]        rdata,
   output logic                     irq
);

   // Word indices (offset >> 2) of the fixed registers.
   localparam logic [4:0] W_IN0    = 5'd8;
   localparam logic [4:0] W_STATUS = 5'd12;
   localparam logic [4:0] W_IRQ_EN = 5'd13;
   localparam logic [4:0] W_TLOAD  = 5'd14;
   localparam logic [4:0] W_TVAL   = 5'd15;
   localparam logic [4:0] W_TCTRL  = 5'd16;
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   logic [4:0] word;
   logic       wr;
   logic       unused_addr;

   // Byte-lane bits and the high address bits between bit 6 and the
   // window bit carry no meaning inside the window.
   assign io_sel      = addr[ADDR_W-1];
   assign word        = addr[6:2];
   assign wr          = we & io_sel;
   assign unused_addr = ^addr;

   logic [N_OUT*DATA_W-1:0] out_q, out_d;
   logic [N_IN*DATA_W-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [N_IN-1:0]         chg_q, chg_d, chg_set;
   logic                    texp_q, texp_d, texp_set;
   logic [DATA_W-1:0]       irq_en_q, irq_en_d;
   logic [DATA_W-1:0]       tload_q, tload_d;
   logic [DATA_W-1:0]       tval_q, tval_d;
   logic                    en_q, en_d;
   logic                    auto_q, auto_d;
   logic [DATA_W-1:0]       status_vec;

   // Output-port registers and the IRQ enable mask take software writes.
   always_comb begin
      out_d    = out_q;
      irq_en_d = irq_en_q;
      for (int i = 0; i < N_OUT; i++) begin
         if (wr && (word == 5'(i))) out_d[i*DATA_W +: DATA_W] = wdata;
      end
      if (wr && (word == W_IRQ_EN)) irq_en_d = wdata;
   end

   // Three-flop input synchroniser; a change is detected between the
   // second and third stage so the flag never sees a metastable value.
   always_comb begin
      s1_d    = in_port;
      s2_d    = s1_q;
      s3_d    = s2_q;
      chg_set = '0;
      for (int j = 0; j < N_IN; j++) begin
         chg_set[j] = (s2_q[j*DATA_W +: DATA_W] != s3_q[j*DATA_W +: DATA_W]);
      end
   end

   // Timer: count down while enabled, flag expiry at zero, then reload or
   // stop. Software writes to LOAD/CTRL are applied last so they win.
   always_comb begin
      tval_d   = tval_q;
      tload_d  = tload_q;
      en_d     = en_q;
      auto_d   = auto_q;
      texp_set = 1'b0;
      if (en_q) begin
         if (tval_q != '0) begin
            tval_d = tval_q - ONE;
         end else begin
            texp_set = 1'b1;
            if (auto_q) tval_d = tload_q;
            else        en_d   = 1'b0;
         end
      end
      if (wr && (word == W_TLOAD)) begin
         tload_d = wdata;
         tval_d  = wdata;
      end
      if (wr && (word == W_TCTRL)) begin
         en_d   = wdata[0];
         auto_d = wdata[1];
      end
   end

   // Sticky status flags: write-one-to-clear, hardware set takes priority.
   always_comb begin
      chg_d  = chg_q;
      texp_d = texp_q;
      if (wr && (word == W_STATUS)) begin
         chg_d = chg_q & ~wdata[N_IN-1:0];
         if (wdata[8]) texp_d = 1'b0;
      end
      chg_d = chg_d | chg_set;
      if (texp_set) texp_d = 1'b1;
   end

   // Assemble the STATUS word and the masked interrupt.
   always_comb begin
      status_vec           = '0;
      status_vec[N_IN-1:0] = chg_q;
      status_vec[8]        = texp_q;
      irq                  = |(status_vec & irq_en_q);
   end

   // Combinational read mux; anything unmapped reads zero.
   always_comb begin
      rdata = '0;
      if (io_sel) begin
         for (int i = 0; i < N_OUT; i++) begin
            if (word == 5'(i)) rdata = out_q[i*DATA_W +: DATA_W];
         end
         // IN ports only occupy the words below STATUS.
         for (int j = 0; j < N_IN; j++) begin
            if ((word == W_IN0 + 5'(j)) && (word < W_STATUS))
               rdata = s2_q[j*DATA_W +: DATA_W];
         end
         case (word)
            W_STATUS: rdata = status_vec;
            W_IRQ_EN: rdata = irq_en_q;
            W_TLOAD:  rdata = tload_q;
            W_TVAL:   rdata = tval_q;
            W_TCTRL:  rdata = {{(DATA_W-2){1'b0}}, auto_q, en_q};
            default:  ;
         endcase
      end
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_q    <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
         chg_q    <= '0;
         texp_q   <= 1'b0;
         irq_en_q <= '0;
         tload_q  <= '0;
         tval_q   <= '0;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
      end else begin
         out_q    <= out_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         chg_q    <= chg_d;
         texp_q   <= texp_d;
         irq_en_q <= irq_en_d;
         tload_q  <= tload_d;
         tval_q   <= tval_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
      end
   end

   assign out_port = out_q;

endmodule

// File: tb/tb_sc_io_bus.sv
// Testbench for sc_io_bus: directed scenarios plus a randomized run, all
// checked against a register-level behavioural model.
module tb_sc_io_bus;

   localparam int DATA_W = 32;
   localparam int N_OUT  = 3;
   localparam int N_IN   = 2;
   localparam int ADDR_W = 8;

   logic                    clock = 1'b0;
   logic                    resetn;
   logic [ADDR_W-1:0]       addr;
   logic [DATA_W-1:0]       wdata;
   logic                    we;
   logic [N_IN*DATA_W-1:0]  in_port;
   logic [N_OUT*DATA_W-1:0] out_port;
   logic                    io_sel;
   logic [DATA_W-1:0]       rdata;
   logic                    irq;

   always #5 clock = ~clock;

   sc_io_bus #(.DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we),
      .in_port(in_port), .out_port(out_port), .io_sel(io_sel),
      .rdata(rdata), .irq(irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DATA_W-1:0] m_out [N_OUT];
   logic [DATA_W-1:0] m_s1 [N_IN];
   logic [DATA_W-1:0] m_s2 [N_IN];
   logic [DATA_W-1:0] m_s3 [N_IN];
   logic [N_IN-1:0]   m_chg;
   logic              m_texp;
   logic [DATA_W-1:0] m_irqen, m_tload, m_tval;
   logic              m_en, m_auto;
   logic [N_IN*DATA_W-1:0] cur_in;

   task automatic model_reset();
      for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
      for (int j = 0; j < N_IN; j++) begin
         m_s1[j] = '0; m_s2[j] = '0; m_s3[j] = '0;
      end
      m_chg = '0; m_texp = 1'b0; m_irqen = '0; m_tload = '0; m_tval = '0;
      m_en = 1'b0; m_auto = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] m_status();
      logic [DATA_W-1:0] r;
      r = '0;
      for (int j = 0; j < N_IN; j++) r[j] = m_chg[j];
      r[8] = m_texp;
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
      int off;
      if (!a[ADDR_W-1]) return '0;
      off = int'(a[6:0]) & 'h7C;
      if (off < 'h20) begin
         if (off / 4 < N_OUT) return m_out[off/4];
         return '0;
      end
      case (off)
         'h30: return m_status();
         'h34: return m_irqen;
         'h38: return m_tload;
         'h3C: return m_tval;
         'h40: return {{(DATA_W-2){1'b0}}, m_auto, m_en};
         default: ;
      endcase
      if (off < 'h30 && (off - 'h20) / 4 < N_IN) return m_s2[(off-'h20)/4];
      return '0;
   endfunction

   function automatic logic [N_OUT*DATA_W-1:0] m_outvec();
      logic [N_OUT*DATA_W-1:0] r;
      for (int i = 0; i < N_OUT; i++) r[i*DATA_W +: DATA_W] = m_out[i];
      return r;
   endfunction

   // One clock edge of the register-level behaviour, from pre-edge values.
   task automatic model_edge(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                             input logic w, input logic [N_IN*DATA_W-1:0] inp);
      logic            wr;
      int              off;
      logic [N_IN-1:0] hw_chg;
      logic            hw_texp;
      wr  = w && a[ADDR_W-1];
      off = int'(a[6:0]) & 'h7C;
      for (int j = 0; j < N_IN; j++) begin
         hw_chg[j] = (m_s2[j] != m_s3[j]);
         m_s3[j]   = m_s2[j];
         m_s2[j]   = m_s1[j];
         m_s1[j]   = inp[j*DATA_W +: DATA_W];
      end
      hw_texp = 1'b0;
      if (m_en) begin
         if (m_tval != 0) m_tval = m_tval - 1;
         else begin
            hw_texp = 1'b1;
            if (m_auto) m_tval = m_tload;
            else        m_en   = 1'b0;
         end
      end
      if (wr) begin
         case (off)
            'h30: begin
               m_chg = m_chg & ~wd[N_IN-1:0];
               if (wd[8]) m_texp = 1'b0;
            end
            'h34: m_irqen = wd;
            'h38: begin m_tload = wd; m_tval = wd; end
            'h40: begin m_en = wd[0]; m_auto = wd[1]; end
            default: if (off < 'h20 && off / 4 < N_OUT) m_out[off/4] = wd;
         endcase
      end
      m_chg = m_chg | hw_chg;
      if (hw_texp) m_texp = 1'b1;
   endtask

   // One bus cycle: drive at the falling edge, check 1 time unit later,
   // then advance the model at the rising edge.
   task automatic cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input logic w, input logic rn, output logic [DATA_W-1:0] rd);
      @(negedge clock);
      addr = a; wdata = wd; we = w; in_port = cur_in; resetn = rn;
      if (!rn) model_reset();
      #1;
      rd = rdata;
      chk("rdata", rdata, m_read(a));
      chk("irq", irq, |(m_status() & m_irqen));
      chk("out_port", out_port, m_outvec());
      chk("io_sel", io_sel, a[ADDR_W-1]);
      @(posedge clock);
      if (rn) model_edge(a, wd, w, cur_in);
   endtask

   logic [DATA_W-1:0] r;
   logic [6:0] offs [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h20, 7'h24,
                             7'h28, 7'h30, 7'h34, 7'h38, 7'h3C, 7'h40};

   initial begin
      resetn = 1'b0; addr = '0; wdata = '0; we = 1'b0; in_port = '0; cur_in = '0;
      model_reset();

      // Reset held with random inputs
      for (int k = 0; k < 4; k++) begin
         cur_in = {$urandom, $urandom};
         cycle(8'($urandom), $urandom, 1'($urandom), 1'b0, r);
         chk("rst_out", out_port, '0);
         chk("rst_irq", irq, 1'b0);
      end
      cycle(8'h80, 32'h1, 1'b1, 1'b0, r); chk("rst_rd80", r, 0);
      cycle(8'hB0, 32'h1, 1'b1, 1'b0, r); chk("rst_rdB0", r, 0);
      cycle(8'hBC, 32'h1, 1'b1, 1'b0, r); chk("rst_rdBC", r, 0);
      cur_in = '0;
      cycle(8'h80, 0, 1'b0, 1'b1, r);
      cycle(8'h80, 0, 1'b0, 1'b1, r); chk("rel_rd80", r, 0);
      chk("rel_out", out_port, '0);

      // Output ports
      cycle(8'h84, 32'hDEADBEEF, 1'b1, 1'b1, r);
      #2 chk("out1_next", out_port[63:32], 32'hDEADBEEF);
      cycle(8'h84, 0, 1'b0, 1'b1, r); chk("rd84", r, 32'hDEADBEEF);
      cycle(8'h8C, 32'h12345678, 1'b1, 1'b1, r);
      cycle(8'h8C, 0, 1'b0, 1'b1, r); chk("rd8C", r, 0);
      cycle(8'h04, 32'h55, 1'b1, 1'b1, r);
      cycle(8'h80, 0, 1'b0, 1'b1, r); chk("nonio_store", r, 0);
      chk("nonio_out", out_port, {32'h0, 32'hDEADBEEF, 32'h0});

      // Input sync and change flag
      cur_in[31:0] = 32'h5;
      cycle(8'hA0, 0, 1'b0, 1'b1, r);                    // edge 1
      cycle(8'hA0, 0, 1'b0, 1'b1, r); chk("in_e1", r, 0);
      cycle(8'hA0, 0, 1'b0, 1'b1, r); chk("in_e2", r, 5);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("chg_e3", r, 1);
      cycle(8'hB4, 32'h1, 1'b1, 1'b1, r);
      #2 chk("irq_en", irq, 1'b1);
      cycle(8'hB0, 32'h1, 1'b1, 1'b1, r);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("w1c_status", r, 0);
      chk("w1c_irq", irq, 1'b0);

      // Timer one-shot
      cycle(8'hB8, 32'd3, 1'b1, 1'b1, r);
      cycle(8'hC0, 32'h1, 1'b1, 1'b1, r);                // edge 0
      cycle(8'hBC, 0, 1'b0, 1'b1, r); chk("os_v3", r, 3);
      cycle(8'hBC, 0, 1'b0, 1'b1, r); chk("os_v2", r, 2);
      cycle(8'hBC, 0, 1'b0, 1'b1, r); chk("os_v1", r, 1);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("os_noexp", r, 0);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("os_texp", r, 32'h100);
      cycle(8'hC0, 0, 1'b0, 1'b1, r); chk("os_en0", r, 0);
      cycle(8'hBC, 0, 1'b0, 1'b1, r); chk("os_hold0", r, 0);

      // Timer auto-reload, W1C racing an expiry
      cycle(8'hB0, 32'h100, 1'b1, 1'b1, r);
      cycle(8'hB8, 32'd2, 1'b1, 1'b1, r);
      cycle(8'hC0, 32'h3, 1'b1, 1'b1, r);                // edge 0
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("ar_e0", r, 0);
      cycle(8'hB0, 0, 1'b0, 1'b1, r);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("ar_e2", r, 0);
      cycle(8'hB0, 32'h100, 1'b1, 1'b1, r); chk("ar_e3", r, 32'h100);
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("ar_clr", r, 0);
      cycle(8'hB0, 32'h100, 1'b1, 1'b1, r);              // W1C at expiry edge
      cycle(8'hB0, 0, 1'b0, 1'b1, r); chk("ar_hw_wins", r, 32'h100);

      // Async reset mid-count
      cycle(8'hC0, 0, 1'b1, 1'b1, r);
      cycle(8'hB8, 32'd7, 1'b1, 1'b1, r);
      cycle(8'hC0, 32'h1, 1'b1, 1'b1, r);
      cycle(8'hBC, 0, 1'b0, 1'b1, r);
      cycle(8'hBC, 0, 1'b0, 1'b1, r);
      cycle(8'hBC, 0, 1'b0, 1'b1, r); chk("mc_v5", r, 5);
      cycle(8'hBC, 0, 1'b0, 1'b0, r); chk("mc_rst_val", r, 0);
      chk("mc_rst_out", out_port, '0);
      cur_in = '0;
      for (int k = 0; k < 10; k++) cycle(8'hB0, 0, 1'b0, 1'b1, r);
      chk("mc_no_texp", r, 0);
      cycle(8'hC0, 0, 1'b0, 1'b1, r); chk("mc_ctrl0", r, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] wd;
         int k;
         k = $urandom_range(0, 11);
         if ($urandom_range(0, 9) == 0) a = {1'b0, 7'($urandom)};
         else a = {1'b1, offs[k] | 7'($urandom_range(0, 3))};
         wd = $urandom;
         if (a[ADDR_W-1] && offs[k] == 7'h38) wd = $urandom_range(0, 6);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) cur_in[31:0] = $urandom;
            else cur_in[63:32] = $urandom;
         end
         cycle(a, wd, ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) != 0), r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
